// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Sequences one data-memory access from the M stage of the pipelined core:
// accepts a load/store, checks alignment, drives a word-wide variable-latency
// memory over a req/ack handshake and returns an extended load result or an
// exception code (1 AdEL, 2 AdES, 3 bus timeout).
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/ready       M-stage request handshake (ready only in IDLE)
//   req_we/op/addr/wdata  request fields, latched on acceptance
//   resp_valid/rdata/exc  one-cycle response pulse with data and code
//   mem_req/we/addr/be/wdata  memory request, held until mem_ack
//   mem_rdata/ack         memory return word and completion strobe
// All outputs decode from the state and latched registers only.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r;
  logic        we_r;
  logic [2:0]  op_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic [1:0]  exc_r;
  logic        bad_s;
  logic        timeout_s;

  // Illegal opcode or misaligned address for the access size.
  function automatic logic is_bad(input logic [2:0] op, input logic [1:0] lo);
    logic r;
    case (op)
      3'b000:         r = (lo != 2'b00);
      3'b001, 3'b010: r = 1'b0;
      3'b011, 3'b100: r = lo[0];
      default:        r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] lo);
    logic [3:0] r;
    case (op)
      3'b000:         r = 4'b1111;
      3'b001, 3'b010: r = 4'b0001 << lo;
      3'b011, 3'b100: r = lo[1] ? 4'b1100 : 4'b0011;
      default:        r = 4'b0000;
    endcase
    return r;
  endfunction

  // Store data replicated into every lane so memory can pick by byte enable.
  function automatic logic [31:0] lane_rep(input logic [2:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      3'b000:         r = d;
      3'b001, 3'b010: r = {4{d[7:0]}};
      3'b011, 3'b100: r = {2{d[15:0]}};
      default:        r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  r = w;
      3'b001:  r = {24'd0, b};
      3'b010:  r = {{24{b[7]}}, b};
      3'b011:  r = {16'd0, h};
      3'b100:  r = {{16{h[15]}}, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign bad_s     = is_bad(req_op, req_addr[1:0]);
  assign timeout_s = (cnt_r == 8'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state decode; ack takes priority over the timeout on the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) state_nxt_s = bad_s ? S_DONE : S_WAIT;
        else           state_nxt_s = S_IDLE;
      end
      S_WAIT: begin
        if (mem_ack || timeout_s) state_nxt_s = S_DONE;
        else                      state_nxt_s = S_WAIT;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Request latch, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= 8'd0;
      we_r    <= 1'b0;
      op_r    <= 3'd0;
      addr_r  <= 32'd0;
      be_r    <= 4'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      exc_r   <= 2'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            we_r    <= req_we;
            op_r    <= req_op;
            addr_r  <= req_addr;
            be_r    <= byte_en(req_op, req_addr[1:0]);
            wdata_r <= lane_rep(req_op, req_wdata);
            rdata_r <= 32'd0;
            cnt_r   <= 8'd0;
            exc_r   <= bad_s ? (req_we ? 2'd2 : 2'd1) : 2'd0;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            rdata_r <= we_r ? 32'd0 : load_ext(op_r, addr_r[1:0], mem_rdata);
            exc_r   <= 2'd0;
          end else if (timeout_s) begin
            rdata_r <= 32'd0;
            exc_r   <= 2'd3;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign req_ready  = (state_r == S_IDLE);
  assign resp_valid = (state_r == S_DONE);
  assign resp_rdata = rdata_r;
  assign resp_exc   = exc_r;
  assign mem_req    = (state_r == S_WAIT);
  assign mem_we     = (state_r == S_WAIT) & we_r;
  assign mem_addr   = {addr_r[31:2], 2'b00};
  assign mem_be     = be_r;
  assign mem_wdata  = wdata_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: expected responses are queued when a
// request is driven and compared when resp_valid pulses.
module tb_dmem_access_ctrl;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad = 0;
  logic [33:0] sb[$];

  dmem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [33:0] e;
    if (resp_valid === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_resp got=%h exp=none", resp_rdata);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e[33:2]);
        chk("resp_exc", {30'd0, resp_exc}, {30'd0, e[1:0]});
      end
    end
  end

  // ack_at: WAIT cycle index (0-based) on which mem_ack is raised, -1 for never.
  task automatic do_access(input string tag, input logic we, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_exc,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    bit is_err;
    bit done;
    is_err = (exp_exc == 2'd1) || (exp_exc == 2'd2);
    done = 1'b0;
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    sb.push_back({exp_rdata, exp_exc});
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = ~we;
    if (is_err) begin
      chk({tag, "_noreq"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_lat"}, {31'd0, resp_valid}, 32'd1);
    end else begin
      for (int i = 0; i < TIMEOUT && !done; i++) begin
        chk({tag, "_mreq"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_nvalid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_maddr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_mbe"}, {28'd0, mem_be}, {28'd0, exp_be});
        chk({tag, "_mwe"}, {31'd0, mem_we}, {31'd0, we});
        if (we) chk({tag, "_mwdata"}, mem_wdata, exp_wdata);
        if (i == ack_at) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        if (i == ack_at) done = 1'b1;
      end
      chk({tag, "_lat"}, {31'd0, resp_valid}, 32'd1);
    end
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_pulse1"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_exc", {30'd0, resp_exc}, 32'd0);
    chk("rst_mreq", {31'd0, mem_req}, 32'd0);
    chk("rst_mwe", {31'd0, mem_we}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mbe", {28'd0, mem_be}, 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);

    //        tag      we    op      addr          wdata         ack rdata         exp_rdata     exc   be       exp_wdata
    do_access("lw",    1'b0, 3'b000, 32'h00000100, 32'h00000000, 0,  32'hDEADBEEF, 32'hDEADBEEF, 2'd0, 4'b1111, 32'h0);
    do_access("lb",    1'b0, 3'b010, 32'h00000103, 32'h00000000, 3,  32'h80FF1234, 32'hFFFFFF80, 2'd0, 4'b1000, 32'h0);
    do_access("lbu",   1'b0, 3'b001, 32'h00000103, 32'h00000000, 3,  32'h80FF1234, 32'h00000080, 2'd0, 4'b1000, 32'h0);
    do_access("sh",    1'b1, 3'b100, 32'h00000206, 32'h0000ABCD, 1,  32'h11111111, 32'h00000000, 2'd0, 4'b1100, 32'hABCDABCD);
    do_access("lh",    1'b0, 3'b100, 32'h00000102, 32'h00000000, 2,  32'h80015555, 32'hFFFF8001, 2'd0, 4'b1100, 32'h0);
    do_access("lhu",   1'b0, 3'b011, 32'h00000100, 32'h00000000, 0,  32'h1234F00D, 32'h0000F00D, 2'd0, 4'b0011, 32'h0);
    do_access("sb",    1'b1, 3'b001, 32'h00000101, 32'hFFFFFF5A, 0,  32'h0,        32'h00000000, 2'd0, 4'b0010, 32'h5A5A5A5A);
    do_access("sw",    1'b1, 3'b000, 32'h00000300, 32'hCAFEF00D, 1,  32'h0,        32'h00000000, 2'd0, 4'b1111, 32'hCAFEF00D);
    do_access("adel",  1'b0, 3'b000, 32'h00000102, 32'h00000000, -1, 32'h0,        32'h00000000, 2'd1, 4'b0000, 32'h0);
    do_access("ades",  1'b1, 3'b100, 32'h00000201, 32'h00001234, -1, 32'h0,        32'h00000000, 2'd2, 4'b0000, 32'h0);
    do_access("illop", 1'b0, 3'b101, 32'h00000100, 32'h00000000, -1, 32'h0,        32'h00000000, 2'd1, 4'b0000, 32'h0);
    do_access("tmo",   1'b0, 3'b000, 32'h00000400, 32'h00000000, -1, 32'h0,        32'h00000000, 2'd3, 4'b1111, 32'h0);
    do_access("ack16", 1'b0, 3'b000, 32'h00000400, 32'h00000000, 15, 32'h12345678, 32'h12345678, 2'd0, 4'b1111, 32'h0);

    // Reset in the second WAIT cycle aborts the access without a response.
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h00000500;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_wait1", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    chk("abort_wait2", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_mreq", {31'd0, mem_req}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_valid", {31'd0, resp_valid}, 32'd0);
    repeat (TIMEOUT + 4) @(negedge clk);

    do_access("post",  1'b0, 3'b010, 32'h00000101, 32'h00000000, 0,  32'h00007F00, 32'h0000007F, 2'd0, 4'b0010, 32'h0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access issued by the M stage of the pipelined MIPS core.
- Accepts one load/store request, checks alignment, and drives a variable-latency word-wide data memory through a req/ack handshake.
- Generates byte enables and lane-replicated store data, and returns a sign- or zero-extended load result.
- Raises AdEL/AdES/bus-timeout exception codes. The pipeline stalls M while req_ready is low.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT without mem_ack before a bus-timeout response; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  M stage presents an access
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  000 W, 001 BU, 010 B, 011 HU, 100 H; 101-111 illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse, result available
- resp_rdata  out  32  extended load data; 0 for stores and exceptions
- resp_exc  out  2  0 none, 1 AdEL, 2 AdES, 3 bus timeout
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write strobe
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word, valid with mem_ack
- mem_ack  in  1  access complete this cycle

Behaviour:
- States: IDLE, WAIT, DONE. All request fields are latched on acceptance. Outputs are decoded from state and latched registers only, so there are no combinational paths from req_* or mem_* inputs to outputs.
- Reset: state=IDLE; timeout counter=0; all latched registers=0. This gives req_ready=1, resp_valid=0, resp_rdata=0, resp_exc=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- IDLE, req_valid=1: acceptance happens at this edge.
  - Error cases: op illegal, or misaligned (W with addr[1:0]!=0; H/HU with addr[0]=1).
    - Next state is DONE with resp_exc = 1 for loads, 2 for stores.
    - No memory transaction is issued.
  - Otherwise: next state is WAIT and the counter is cleared.
- WAIT:
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata stay stable for the whole state.
  - mem_ack=1 at the edge: capture the extended load data and go to DONE with resp_exc=0.
  - No ack: the counter increments. When counter==TIMEOUT-1 without ack, go to DONE with resp_exc=3 and resp_rdata=0.
  - If mem_ack arrives on that same cycle, ack wins.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in DONE, so there are no back-to-back acceptances.
- Byte enables:
  - W: 1111.
  - H/HU: 0011 if addr[1]=0, else 1100.
  - B/BU: 4'b0001 << addr[1:0].
  - Loads use the same mem_be as stores; memory may ignore it.
- Store data:
  - W: wdata.
  - H: {2{wdata[15:0]}}.
  - B: {4{wdata[7:0]}}.
- Load extension: select the byte at addr[1:0] or the half at addr[1]. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Latency:
  - Accept at edge 0; mem_req is high in cycle 1.
  - Ack sampled at edge 1 gives resp_valid in cycle 2, so the minimum is 2 cycles.
  - Exception path gives resp_valid in cycle 1.
- Reset asserted in WAIT or DONE aborts the access. mem_req and resp_valid are 0 after that edge, and the aborted access produces no response.
- mem_ack outside WAIT is ignored.
- req_valid outside IDLE is ignored; the requester holds the request until req_ready.

Test Plan:
- Reset, then LW addr=0x100: memory acks in the first WAIT cycle with rdata 0xDEADBEEF -> mem_be=1111, mem_addr=0x100, resp_valid in cycle 2, resp_rdata=0xDEADBEEF, resp_exc=0.
- LB/LBU addr=0x103, mem_rdata=0x80FF1234, ack after 3 wait cycles -> LB returns 0xFFFFFF80 and LBU returns 0x00000080. mem_req stays high with stable fields for all 4 WAIT cycles.
- SH addr=0x206, wdata=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, resp_rdata=0, resp_exc=0.
- LW addr=0x102 -> resp_exc=1 one cycle after acceptance with no mem_req. SH addr=0x201 -> resp_exc=2. Illegal op 101 with load -> resp_exc=1.
- TIMEOUT=16, no ack -> resp_exc=3 after exactly 16 WAIT cycles, then IDLE. Rerun with ack on the 16th WAIT cycle -> resp_exc=0 with data.
- Reset pulsed in the 2nd WAIT cycle -> next cycle mem_req=0, req_ready=1, and no resp_valid pulse ever appears for the aborted access.
